// File: rtl/mtimer_multi.sv
// Multi-hart machine timer: 64-bit mtime with a programmable prescaler, per-hart mtimecmp
// comparators driving mtip, per-hart software interrupt bits and a registered read port.
module mtimer_multi #(
    parameter int unsigned NUM_HARTS = 2,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clnt_en,
    input  logic                 re,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    clnt_addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 rvalid,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip,
    output logic                 tick
);

    logic [63:0]          mtime_q, mtime_d;
    logic [31:0]          prescale_q;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          snap_q;
    logic                 enable_q;
    logic [63:0]          cmp_q [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, mtip_q;
    logic [31:0]          dout_q;
    logic                 rvalid_q, tick_q;

    logic [31:0] addr;
    logic [31:0] rdata;
    logic        wr, rd, wr_lo, wr_hi, presc_clr, hit, inc;

    assign addr      = 32'(clnt_addr);
    assign wr        = clnt_en && we;
    assign rd        = clnt_en && re;
    assign wr_lo     = wr && (addr == 32'd0);
    assign wr_hi     = wr && (addr == 32'd1);
    assign presc_clr = wr && (addr == 32'd4) && din[1];
    assign hit       = (cnt_q == prescale_q);
    // A software write to either mtime half steals the increment of that cycle.
    assign inc       = enable_q && hit && !presc_clr && !wr_lo && !wr_hi;

    always_comb begin
        cnt_d = cnt_q;
        if (presc_clr) begin
            cnt_d = '0;
        end else if (enable_q) begin
            cnt_d = hit ? 32'd0 : cnt_q + 32'd1;
        end
    end

    always_comb begin
        mtime_d = mtime_q;
        if (wr_lo) begin
            mtime_d[31:0] = din;
        end else if (wr_hi) begin
            mtime_d[63:32] = din;
        end else if (inc) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            32'd0:   rdata = mtime_q[31:0];
            32'd1:   rdata = mtime_q[63:32];
            32'd2:   rdata = snap_q;
            32'd3:   rdata = prescale_q;
            32'd4:   rdata = {31'b0, enable_q};
            default: rdata = '0;
        endcase
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (addr == 8 + 2 * h)             rdata = cmp_q[h][31:0];
            if (addr == 9 + 2 * h)             rdata = cmp_q[h][63:32];
            if (addr == 8 + 2 * NUM_HARTS + h) rdata = {31'b0, msip_q[h]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            prescale_q <= '0;
            cnt_q      <= '0;
            enable_q   <= 1'b1;
            snap_q     <= '0;
            msip_q     <= '0;
            mtip_q     <= '0;
            dout_q     <= '0;
            rvalid_q   <= 1'b0;
            tick_q     <= 1'b0;
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                cmp_q[h] <= '1;
            end
        end else begin
            mtime_q  <= mtime_d;
            cnt_q    <= cnt_d;
            tick_q   <= inc;
            rvalid_q <= rd;
            dout_q   <= rd ? rdata : 32'd0;
            // Latch the hi half alongside a lo read so a later hi read is carry-consistent.
            if (rd && addr == 32'd0) snap_q <= mtime_q[63:32];
            if (wr && addr == 32'd3) prescale_q <= din;
            if (wr && addr == 32'd4) enable_q <= din[0];
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (wr && addr == 8 + 2 * h)             cmp_q[h][31:0]  <= din;
                if (wr && addr == 9 + 2 * h)             cmp_q[h][63:32] <= din;
                if (wr && addr == 8 + 2 * NUM_HARTS + h) msip_q[h]       <= din[0];
                mtip_q[h] <= (mtime_q >= cmp_q[h]);
            end
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign mtip   = mtip_q;
    assign msip   = msip_q;
    assign tick   = tick_q;

endmodule

// File: doc/mtimer_multi.md
MTIMER_MULTI -- requirements
Module: mtimer_multi

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 2, number of timer/software-interrupt channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_W, default 5, word-address width of the register port.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port clnt_en  in  1  block select for the current access.
REQ-006 SHALL have port re  in  1  read strobe, qualified by clnt_en.
REQ-007 SHALL have port we  in  1  write strobe, qualified by clnt_en.
REQ-008 SHALL have port clnt_addr  in  ADDR_W  32-bit word address.
REQ-009 SHALL have port din  in  32  write data.
REQ-010 SHALL have port dout  out  32  registered read data.
REQ-011 SHALL have port rvalid  out  1  read data valid.
REQ-012 SHALL have port mtip  out  NUM_HARTS  per-hart timer interrupt.
REQ-013 SHALL have port msip  out  NUM_HARTS  per-hart software interrupt.
REQ-014 SHALL have port tick  out  1  one-cycle pulse on every mtime increment.

Function
REQ-015 SHALL use this register map: 0 mtime[31:0], 1 mtime[63:32] live, 2 mtime-hi snapshot (RO), 3 prescale[31:0], 4 ctrl, 8+2h mtimecmp[h][31:0], 9+2h mtimecmp[h][63:32], 8+2*NUM_HARTS+h msip[h] (bit0 only).
REQ-016 SHALL treat ctrl as bit0 enable (RW), bit1 prescaler clear (write-1 pulse, reads 0), other bits read 0.
REQ-017 SHALL run an internal 32-bit prescale counter while enable=1: when counter==prescale, counter goes to 0 and mtime increments by 1 (64-bit, wraps FFFF_FFFF_FFFF_FFFF->0); else counter+1.
REQ-018 SHALL with prescale=0 increment mtime every cycle while enabled; with enable=0 freeze both counter and mtime.
REQ-019 SHALL on a write to address 0 or 1 load that half from din, hold the other half, and suppress the increment in that cycle; prescale counter continues unaffected.
REQ-020 SHALL on ctrl write with bit1=1 zero the prescale counter that cycle (no increment that cycle).
REQ-021 SHALL on a read of address 0 capture mtime[63:32] into the snapshot register in the same cycle as the lo value is sampled.
REQ-022 SHALL register reads: clnt_en&&re in cycle N -> dout holds the cycle-N register value and rvalid=1 in cycle N+1; otherwise dout=0, rvalid=0.
REQ-023 SHALL when re and we coincide to the same address perform the write and return the pre-write value.
REQ-024 SHALL return 0 for reads of unmapped addresses (including hart indices >= NUM_HARTS) and ignore writes to them; rvalid still asserts.
REQ-025 SHALL register mtip[h] = (mtime >= mtimecmp[h]) unsigned 64-bit, from current register values, one cycle latency; mtip re-evaluates every cycle, clearing only via mtimecmp or mtime change.
REQ-026 SHALL drive msip[h] directly from msip register bit0 (no extra latency beyond the write).
REQ-027 SHALL pulse tick for exactly the cycles in which mtime increments via REQ-017 (not on software writes).

Reset
REQ-028 SHALL while rst_n=0 at a clock edge set mtime=0, prescale=0, prescale counter=0, ctrl.enable=1, snapshot=0, every mtimecmp=FFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, dout=0, rvalid=0, tick=0.
REQ-029 SHALL abort any in-flight read on reset (rvalid=0 next cycle) and ignore accesses during reset.
REQ-030 SHALL begin counting on the first clock edge with rst_n=1.

Verification
REQ-031 SHALL cover: reset, prescale=3 -> mtime increments every 4 cycles, tick pulses 1 cycle each time.
REQ-032 SHALL cover: mtime={0000_0000,FFFF_FFFE}, prescale=0, read addr 0 then addr 2 -> snapshot matches hi at lo read despite carry into hi.
REQ-033 SHALL cover: mtimecmp[1]=0x20, mtime from 0 -> mtip[1] rises the cycle after mtime==0x20, mtip[0] stays 0; writing mtimecmp[1]=FFFF_FFFF clears it next cycle.
REQ-034 SHALL cover: write msip[0]=1 -> msip[0]=1 next cycle; read/write of address 8+2*NUM_HARTS+NUM_HARTS -> dout=0, no state change.
REQ-035 SHALL cover: simultaneous re/we to address 3 with din=7 -> dout returns old prescale, then 7 on re-read; enable=0 freezes mtime and tick.
REQ-036 SHALL cover: rst_n low for one cycle mid-read and mid-count -> all REQ-028 values, rvalid=0.
